// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtract cell reused over W cycles, LSB first.
// Optional signed-overflow flag output when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff_out,
  output logic         borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, d_sh;
  logic          brw;
  logic [CW-1:0] cnt;
  logic          cell_d, cell_b;
  logic          last;

  // The shared 1-bit cell: returns {borrow, diff} for a - b - cin.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic cin);
    logic d, bo;
    d  = a ^ b ^ cin;
    bo = (~a & b) | (~(a ^ b) & cin);
    return {bo, d};
  endfunction

  assign {cell_b, cell_d} = full_sub(a_sh[0], b_sh[0], brw);
  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        a_sh <= a_in;
        b_sh <= b_in;
        brw  <= bin;
        cnt  <= '0;
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {cell_d, d_sh[W-1:1]};
      brw  <= cell_b;
      // Wrap explicitly so cnt stays within 0..W-1 for non-power-of-two W.
      cnt  <= last ? '0 : cnt + CW'(1);
      if (last) begin
        diff_out   <= {cell_d, d_sh[W-1:1]};
        borrow_out <= cell_b;
`ifdef SERIAL_SUB_OVF_EN
        // brw here is the borrow into the MSB; cell_b is the borrow out of it.
        ovf        <= brw ^ cell_b;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl against an arithmetic reference model.
// Honors SERIAL_SUB_OVF_EN for the optional ovf output.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin = 1'b0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_diff = '0;
  logic         prev_brw  = 1'b0;

  serial_sub_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, borrow, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    longint d, sd, lim;
    logic   o;
    d   = longint'(a) - longint'(b) - longint'(bi);
    sd  = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    lim = longint'(1) <<< (W - 1);
    o   = (sd < -lim) || (sd > lim - 1);
    return {o, (d < 0), W'(d)};
  endfunction

  task automatic check_result(input string tag, input logic [W+1:0] m);
    check({tag, "_diff"}, 32'(diff_out), 32'(m[W-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(m[W]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(m[W+1]));
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W+1:0] m;
    m = model(a, b, bi);
    @(negedge clk);
    a_in = a; b_in = b; bin = bi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); bin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i < W) begin
        check("done_early", 32'(done), 32'd0);
        check("hold_diff", 32'(diff_out), 32'(prev_diff));
        check("hold_borrow", 32'(borrow_out), 32'(prev_brw));
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check_result("op", m);
      end
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    prev_diff = m[W-1:0];
    prev_brw  = m[W];
  endtask

  localparam int NC = W + 4 * (W + 2) + 1;
  logic [W-1:0] ha [NC];
  logic [W-1:0] hb [NC];
  logic         hi [NC];

  initial begin
    // Reset held with start asserted.
    start = 1'b1; a_in = 8'h5A; b_in = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff_out), 32'd0);
      check("rst_borrow", 32'(borrow_out), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h33, 8'h33, 1'b0);
    run_op(8'h33, 8'h33, 1'b1);

    // Random operands.
    for (int n = 0; n < 30; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    // Start held high with operands changing every cycle.
    begin
      int last_done = -1;
      int ndone = 0;
      for (int c = 0; c < NC; c++) begin
        @(negedge clk);
        ha[c] = W'($urandom); hb[c] = W'($urandom); hi[c] = 1'($urandom);
        a_in = ha[c]; b_in = hb[c]; bin = hi[c]; start = 1'b1;
        @(posedge clk);
        #1;
        if (done) begin
          if (c >= W) begin
            logic [W+1:0] m;
            m = model(ha[c-W], hb[c-W], hi[c-W]);
            check_result("cont", m);
            prev_diff = m[W-1:0];
            prev_brw  = m[W];
          end else begin
            check("cont_early_done", 32'(c), 32'(W));
          end
          if (last_done >= 0) check("cont_spacing", 32'(c - last_done), 32'(W + 2));
          last_done = c;
          ndone++;
        end else if (busy) begin
          check("cont_hold", 32'(diff_out), 32'(prev_diff));
        end
      end
      check("cont_count", 32'(ndone), 32'd5);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("cont_idle_busy", 32'(busy), 32'd0);
      check("cont_idle_done", 32'(done), 32'd0);
    end

    // Reset mid-RUN at cnt==3.
    @(negedge clk);
    a_in = 8'hC3; b_in = 8'h12; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff_out), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    prev_diff = '0;
    prev_brw  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
